// File: rtl/mux_sel_scan.sv
// Round-robin channel scanner: steps the downstream 4:1 mux select across enabled
// channels, one slot of DIV cycles each, and snapshots x0..x3 at every frame boundary.
// Optional feature macro: SCAN_HOLD_EN adds a 'hold' input that freezes the scan.
module mux_sel_scan #(
    parameter int WIDTH = 3,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef SCAN_HOLD_EN
    input  logic             hold,
`endif
    input  logic [3:0]       mask,
    input  logic [WIDTH-1:0] x0,
    input  logic [WIDTH-1:0] x1,
    input  logic [WIDTH-1:0] x2,
    input  logic [WIDTH-1:0] x3,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [1:0]       a,
    output logic             valid,
    output logic             wrap
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

`ifdef SCAN_HOLD_EN
    logic hold_w;
    assign hold_w = hold;
`else
    logic hold_w;
    assign hold_w = 1'b0;
`endif

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0]       a_q, a_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] q0_q, q0_d, q1_q, q1_d, q2_q, q2_d, q3_q, q3_d;
    logic             tick;
    logic [1:0]       a_nxt;

    // First set mask bit after cur, searching cur+1..cur+4 (the last wraps back to cur).
    function automatic logic [1:0] next_chan(input logic [1:0] cur, input logic [3:0] m);
        logic [1:0] idx;
        logic       found;
        next_chan = cur;
        found     = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && m[idx]) begin
                next_chan = idx;
                found     = 1'b1;
            end
        end
    endfunction

    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        q0_d    = q0_q;
        q1_d    = q1_q;
        q2_d    = q2_q;
        q3_d    = q3_q;
        tick    = 1'b0;
        a_nxt   = next_chan(a_q, mask);
        if (!hold_w) begin
            if (en) begin
                tick  = (cnt_q == CNT_MAX);
                cnt_d = tick ? '0 : cnt_q + CW'(1);
            end
            if (tick) begin
                a_d = a_nxt;
                // Landing at or below the old select means the scan has wrapped.
                if ((mask != 4'b0000) && (a_nxt <= a_q)) begin
                    wrap_d = 1'b1;
                    q0_d   = x0;
                    q1_d   = x1;
                    q2_d   = x2;
                    q3_d   = x3;
                end
            end
            valid_d = en & mask[a_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            a_q     <= 2'd0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            q0_q    <= '0;
            q1_q    <= '0;
            q2_q    <= '0;
            q3_q    <= '0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            q0_q    <= q0_d;
            q1_q    <= q1_d;
            q2_q    <= q2_d;
            q3_q    <= q3_d;
        end
    end

    assign a     = a_q;
    assign valid = valid_q;
    assign wrap  = wrap_q;
    assign q0    = q0_q;
    assign q1    = q1_q;
    assign q2    = q2_q;
    assign q3    = q3_q;

endmodule

// File: tb/tb_mux_sel_scan.sv
// Directed bench for mux_sel_scan (WIDTH=3, DIV=4) with hand-computed expectations.
module tb_mux_sel_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       hold;
    logic [3:0] mask;
    logic [2:0] x0, x1, x2, x3;
    logic [2:0] q0, q1, q2, q3;
    logic [1:0] a;
    logic       valid;
    logic       wrap;

    int n_vec = 0;
    int n_err = 0;
    int wraps;

    mux_sel_scan #(.WIDTH(3), .DIV(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
`ifdef SCAN_HOLD_EN
        .hold  (hold),
`endif
        .mask  (mask),
        .x0    (x0),
        .x1    (x1),
        .x2    (x2),
        .x3    (x3),
        .q0    (q0),
        .q1    (q1),
        .q2    (q2),
        .q3    (q3),
        .a     (a),
        .valid (valid),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; hold = 1'b0; mask = 4'b1111;
        x0 = 3'd1; x1 = 3'd2; x2 = 3'd3; x3 = 3'd4;
        adv(2);
        check("rst_a", a, 0);
        check("rst_valid", valid, 0);
        check("rst_wrap", wrap, 0);
        check("rst_q0", q0, 0);
        check("rst_q3", q3, 0);
        rst = 1'b0;

        // Full mask: a steps 0,1,2,3,0 every 4 cycles
        adv(1);
        check("full_valid_e1", valid, 1);
        check("full_a_e1", a, 0);
        adv(2);
        check("full_a_e3", a, 0);
        adv(1);
        check("full_a_e4", a, 1);
        adv(4);
        check("full_a_e8", a, 2);
        adv(7);
        check("full_a_e15", a, 3);
        check("full_wrap_e15", wrap, 0);
        check("full_q0_pre", q0, 0);
        adv(1);
        check("full_a_e16", a, 0);
        check("full_wrap_e16", wrap, 1);
        check("full_q0", q0, 1);
        check("full_q1", q1, 2);
        check("full_q2", q2, 3);
        check("full_q3", q3, 4);
        adv(1);
        check("full_wrap_e17", wrap, 0);
        wraps = 0;
        for (int i = 0; i < 15; i++) begin
            adv(1);
            wraps += int'(wrap);
            check("full_valid_loop", valid, 1);
        end
        check("full_wrap_count", wraps, 1);
        check("full_wrap_e32", wrap, 1);

        // en dropped for 5 cycles with cnt=2
        adv(2);
        en = 1'b0;
        adv(1);
        check("en_valid_off", valid, 0);
        adv(4);
        check("en_a_frozen", a, 0);
        check("en_valid_off2", valid, 0);
        en = 1'b1;
        adv(1);
        check("en_valid_back", valid, 1);
        check("en_a_e40", a, 0);
        adv(1);
        check("en_a_tick", a, 1);

        // mask 1010 from a=1: 1,3,1,3 with wrap after each 3->1
        mask = 4'b1010;
        x0 = 3'd5; x1 = 3'd6; x2 = 3'd7; x3 = 3'd0;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            wraps += int'(wrap);
            check("m1010_a_odd", a[0], 1);
            check("m1010_valid", valid, 1);
            if (i == 3) check("m1010_a_3", a, 3);
            if (i == 7) check("m1010_a_1", a, 1);
        end
        check("m1010_wraps", wraps, 2);
        check("m1010_wrap_last", wrap, 1);
        check("m1010_q0", q0, 5);
        check("m1010_q2", q2, 7);

        // Current channel disabled mid-slot: valid drops next cycle, a holds until tick
        mask = 4'b1000;
        adv(1);
        check("mid_valid_drop", valid, 0);
        check("mid_a_hold", a, 1);
        adv(3);
        check("mid_a_tick", a, 3);
        check("mid_valid_back", valid, 1);
        check("mid_wrap_none", wrap, 0);
        adv(4);
        check("single_a", a, 3);
        check("single_wrap", wrap, 1);

        // mask 0: a holds, valid 0, no wrap, q unchanged
        mask = 4'b0000;
        x0 = 3'd1; x1 = 3'd1; x2 = 3'd1; x3 = 3'd1;
        wraps = 0;
        for (int i = 0; i < 16; i++) begin
            adv(1);
            wraps += int'(wrap);
            check("m0_valid", valid, 0);
        end
        check("m0_a", a, 3);
        check("m0_wraps", wraps, 0);
        check("m0_q0", q0, 5);
        check("m0_q1", q1, 6);

        // Reset with a=2, cnt=3
        mask = 4'b1111;
        adv(15);
        check("pre_rst_a", a, 2);
        rst = 1'b1;
        adv(1);
        check("rst2_a", a, 0);
        check("rst2_valid", valid, 0);
        check("rst2_wrap", wrap, 0);
        check("rst2_q0", q0, 0);
        check("rst2_q1", q1, 0);
        rst = 1'b0;
        adv(3);
        check("rst2_a_e3", a, 0);
        adv(1);
        check("rst2_a_e4", a, 1);
        check("rst2_q0_still0", q0, 0);

`ifdef SCAN_HOLD_EN
        // hold for 6 cycles across a would-be tick
        adv(2);
        hold = 1'b1;
        wraps = 0;
        for (int i = 0; i < 6; i++) begin
            adv(1);
            wraps += int'(wrap);
        end
        check("hold_a", a, 1);
        check("hold_wraps", wraps, 0);
        check("hold_valid", valid, 1);
        hold = 1'b0;
        adv(1);
        check("hold_resume_a", a, 1);
        adv(1);
        check("hold_resume_tick", a, 2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
